data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl_pkg.sv | 51 +++++
 rtl/data_mem_ctrl_if.sv | 32 +++
 rtl/data_mem_ctrl_load_extend.sv | 26 ++
 rtl/data_mem_ctrl.sv | 99 +++++++++
 tb/tb_data_mem_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// Shared encodings and helpers for the data-memory controller.
package data_mem_ctrl_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B, F3_BU: byte_enables = 4'b0001 << off;
      F3_H, F3_HU: byte_enables = 4'b0011 << {off[1], 1'b0};
      default:     byte_enables = 4'b1111;
    endcase
  endfunction

  // Store data is replicated so every candidate lane carries it; byte enables pick the lane.
  function automatic logic [DATA_W-1:0] lane_data(input logic [2:0] f3, input logic [DATA_W-1:0] wd);
    case (f3)
      F3_B:    lane_data = {4{wd[7:0]}};
      F3_H:    lane_data = {2{wd[15:0]}};
      default: lane_data = wd;
    endcase
  endfunction

  // Exactly one of load/store, a size valid for that direction, and natural alignment.
  function automatic logic req_legal(input logic rd, input logic wr,
                                     input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    ok = rd ^ wr;
    case (f3)
      F3_B:    ok = ok;
      F3_BU:   ok = ok & rd;
      F3_H:    ok = ok & ~off[0];
      F3_HU:   ok = ok & rd & ~off[0];
      F3_W:    ok = ok & (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Pipeline-side and memory-side signals of the data-memory controller.
interface data_mem_ctrl_if;
  import data_mem_ctrl_pkg::*;

  logic              d_mem_r;
  logic              d_mem_w;
  logic [2:0]        fun_3;
  logic [DATA_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic              busywait;
  logic [DATA_W-1:0] read_data;
  logic              misaligned;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writedata;
  logic [3:0]        mem_byteen;
  logic [DATA_W-1:0] mem_readdata;
  logic              mem_ack;

  modport slave (
    input  d_mem_r, d_mem_w, fun_3, address, write_data, mem_readdata, mem_ack,
    output busywait, read_data, misaligned, mem_read, mem_write,
           mem_address, mem_writedata, mem_byteen
  );

  modport master (
    output d_mem_r, d_mem_w, fun_3, address, write_data, mem_readdata, mem_ack,
    input  busywait, read_data, misaligned, mem_read, mem_write,
           mem_address, mem_writedata, mem_byteen
  );
endinterface

// File: rtl/data_mem_ctrl_load_extend.sv
// Selects the addressed byte/half of a memory word and sign- or zero-extends it.
module load_extend
  import data_mem_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [2:0]        fun_3,
  input  logic [1:0]        offset,
  output logic [DATA_W-1:0] result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[{offset, 3'b000} +: 8];
    lane_h = offset[1] ? word[31:16] : word[15:0];
    case (fun_3)
      F3_B:    result = {{24{lane_b[7]}}, lane_b};
      F3_H:    result = {{16{lane_h[15]}}, lane_h};
      F3_BU:   result = {24'b0, lane_b};
      F3_HU:   result = {16'b0, lane_h};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: stalls the pipeline while one load/store is handshaken with memory.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  data_mem_ctrl_if.slave bus
);

  state_t            state, state_nxt;
  logic              req, legal, start, busy;
  logic [2:0]        fun3_p1;
  logic [1:0]        off_p1;
  logic [DATA_W-1:0] load_word;

  logic              mem_read_q, mem_write_q, misaligned_q;
  logic [DATA_W-1:0] mem_address_q, mem_writedata_q, read_data_q;
  logic [3:0]        mem_byteen_q;

  assign req   = bus.d_mem_r | bus.d_mem_w;
  assign legal = req_legal(bus.d_mem_r, bus.d_mem_w, bus.fun_3, bus.address[1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (legal) begin
          start     = 1'b1;
          busy      = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        busy = 1'b1;
        if (bus.mem_ack) state_nxt = DONE;
      end
      // The stalled instruction is still presented here, so it must not be resampled.
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- request capture / completion stage ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      mem_byteen_q    <= 4'b0000;
      read_data_q     <= '0;
      misaligned_q    <= 1'b0;
    end else begin
      misaligned_q <= (state == IDLE) && req && !legal;
      if (start) begin
        mem_read_q      <= bus.d_mem_r;
        mem_write_q     <= bus.d_mem_w;
        mem_address_q   <= {bus.address[31:2], 2'b00};
        mem_writedata_q <= lane_data(bus.fun_3, bus.write_data);
        mem_byteen_q    <= byte_enables(bus.fun_3, bus.address[1:0]);
      end else if ((state == ACCESS) && bus.mem_ack) begin
        mem_read_q  <= 1'b0;
        mem_write_q <= 1'b0;
        if (mem_read_q) read_data_q <= load_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      fun3_p1 <= bus.fun_3;
      off_p1  <= bus.address[1:0];
    end
  end

  load_extend u_load_extend (
    .word   (bus.mem_readdata),
    .fun_3  (fun3_p1),
    .offset (off_p1),
    .result (load_word)
  );

  assign bus.busywait      = busy & ~reset;
  assign bus.read_data     = read_data_q;
  assign bus.misaligned    = misaligned_q;
  assign bus.mem_read      = mem_read_q;
  assign bus.mem_write     = mem_write_q;
  assign bus.mem_address   = mem_address_q;
  assign bus.mem_writedata = mem_writedata_q;
  assign bus.mem_byteen    = mem_byteen_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed vector table, reset-abort sequence, random traffic vs. a byte-array model.
module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_mem_ctrl_if bus();

  data_mem_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] rd_model;
  logic [7:0]  mem [0:255];

  typedef struct {
    logic        r;
    logic        w;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    int          delay;
    logic [31:0] word;
    logic        ok;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busywait"},   32'(bus.busywait),   32'h0);
    chk({tag, "_read_data"},  bus.read_data,       32'h0);
    chk({tag, "_misaligned"}, 32'(bus.misaligned), 32'h0);
    chk({tag, "_mem_read"},   32'(bus.mem_read),   32'h0);
    chk({tag, "_mem_write"},  32'(bus.mem_write),  32'h0);
    chk({tag, "_mem_addr"},   bus.mem_address,     32'h0);
    chk({tag, "_mem_wdata"},  bus.mem_writedata,   32'h0);
    chk({tag, "_mem_byteen"}, 32'(bus.mem_byteen), 32'h0);
  endtask

  // Starts and ends at 1 time unit after a rising edge with the controller idle.
  task automatic run_txn(input logic r, input logic w, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input int delay,
                         input logic [31:0] word, input logic exp_ok, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_rd);
    bus.d_mem_r    = r;
    bus.d_mem_w    = w;
    bus.fun_3      = f3;
    bus.address    = addr;
    bus.write_data = wd;
    bus.mem_ack    = 1'b0;
    if (!exp_ok) begin
      @(negedge clk);
      chk("bad_busywait", 32'(bus.busywait), 32'h0);
      chk("bad_mem_req",  {30'b0, bus.mem_read, bus.mem_write}, 32'h0);
      next_cycle();
      bus.d_mem_r = 1'b0;
      bus.d_mem_w = 1'b0;
      @(negedge clk);
      chk("bad_misaligned_pulse", 32'(bus.misaligned), 32'h1);
      chk("bad_mem_req_after",    {30'b0, bus.mem_read, bus.mem_write}, 32'h0);
      next_cycle();
      @(negedge clk);
      chk("bad_misaligned_end", 32'(bus.misaligned), 32'h0);
      chk("bad_read_data",      bus.read_data, exp_rd);
      next_cycle();
    end else begin
      @(negedge clk);
      chk("req_busywait",   32'(bus.busywait),   32'h1);
      chk("req_misaligned", 32'(bus.misaligned), 32'h0);
      next_cycle();
      for (int k = 1; k <= delay; k++) begin
        bus.mem_ack      = (k == delay);
        bus.mem_readdata = (k == delay) ? word : $urandom();
        @(negedge clk);
        chk("acc_busywait",  32'(bus.busywait),  32'h1);
        chk("acc_mem_read",  32'(bus.mem_read),  32'(r));
        chk("acc_mem_write", 32'(bus.mem_write), 32'(w));
        chk("acc_mem_addr",  bus.mem_address,    {addr[31:2], 2'b00});
        chk("acc_byteen",    32'(bus.mem_byteen), 32'(exp_be));
        if (w) chk("acc_wdata", bus.mem_writedata, exp_wdata);
        next_cycle();
      end
      bus.mem_ack      = 1'b0;
      bus.mem_readdata = $urandom();
      @(negedge clk);
      chk("done_busywait", 32'(bus.busywait), 32'h0);
      chk("done_mem_req",  {30'b0, bus.mem_read, bus.mem_write}, 32'h0);
      chk("done_read_data", bus.read_data, exp_rd);
      next_cycle();
      bus.d_mem_r = 1'b0;
      bus.d_mem_w = 1'b0;
      @(negedge clk);
      chk("idle_busywait",  32'(bus.busywait), 32'h0);
      chk("idle_read_data", bus.read_data, exp_rd);
      next_cycle();
    end
  endtask

  initial begin
    logic        r, w, ok, sgn;
    logic [2:0]  f3;
    logic [31:0] addr, wd, word, wdata;
    logic [3:0]  be;
    logic [2:0]  store_f3 [9];
    int          size, off, base, delay, kind;
    longint      v;

    vecs[0]  = '{1'b1, 1'b0, F3_W,   32'h100, 32'h0,        3, 32'hDEADBEEF, 1'b1, 4'b1111, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{1'b1, 1'b0, F3_B,   32'h103, 32'h0,        1, 32'h80FF0000, 1'b1, 4'b1000, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{1'b1, 1'b0, F3_BU,  32'h103, 32'h0,        2, 32'h80FF0000, 1'b1, 4'b1000, 32'h0,        32'h00000080};
    vecs[3]  = '{1'b0, 1'b1, F3_H,   32'h202, 32'h00001234, 2, 32'h0,        1'b1, 4'b1100, 32'h12341234, 32'h00000080};
    vecs[4]  = '{1'b1, 1'b0, F3_W,   32'h101, 32'h0,        0, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h00000080};
    vecs[5]  = '{1'b1, 1'b1, F3_W,   32'h100, 32'h0,        0, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h00000080};
    vecs[6]  = '{1'b1, 1'b0, F3_H,   32'h102, 32'h0,        2, 32'h80017FFF, 1'b1, 4'b1100, 32'h0,        32'hFFFF8001};
    vecs[7]  = '{1'b1, 1'b0, F3_HU,  32'h100, 32'h0,        1, 32'h80017FFF, 1'b1, 4'b0011, 32'h0,        32'h00007FFF};
    vecs[8]  = '{1'b0, 1'b1, F3_B,   32'h005, 32'h123456AB, 4, 32'h0,        1'b1, 4'b0010, 32'hABABABAB, 32'h00007FFF};
    vecs[9]  = '{1'b1, 1'b0, F3_H,   32'h101, 32'h0,        0, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h00007FFF};
    vecs[10] = '{1'b1, 1'b0, 3'b011, 32'h100, 32'h0,        0, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h00007FFF};
    vecs[11] = '{1'b0, 1'b1, F3_W,   32'h010, 32'hCAFEF00D, 1, 32'h0,        1'b1, 4'b1111, 32'hCAFEF00D, 32'h00007FFF};

    store_f3 = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

    reset            = 1'b1;
    bus.d_mem_r      = 1'b0;
    bus.d_mem_w      = 1'b0;
    bus.fun_3        = 3'b000;
    bus.address      = 32'h0;
    bus.write_data   = 32'h0;
    bus.mem_readdata = 32'h0;
    bus.mem_ack      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    next_cycle();
    reset = 1'b0;
    next_cycle();

    for (int i = 0; i < 12; i++)
      run_txn(vecs[i].r, vecs[i].w, vecs[i].f3, vecs[i].addr, vecs[i].wd, vecs[i].delay,
              vecs[i].word, vecs[i].ok, vecs[i].be, vecs[i].wdata, vecs[i].rd);

    // Stray acknowledge while idle must not disturb anything.
    bus.mem_ack      = 1'b1;
    bus.mem_readdata = 32'h11111111;
    @(negedge clk);
    chk("stray_ack_busywait", 32'(bus.busywait), 32'h0);
    next_cycle();
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_read_data", bus.read_data, 32'h00007FFF);
    chk("stray_ack_mem_req",   {30'b0, bus.mem_read, bus.mem_write}, 32'h0);
    next_cycle();

    // Reset in the second ACCESS cycle of a word store.
    bus.d_mem_w    = 1'b1;
    bus.fun_3      = F3_W;
    bus.address    = 32'h300;
    bus.write_data = 32'h55AA55AA;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("abort_pre_mem_write", 32'(bus.mem_write), 32'h1);
    #1 reset = 1'b1;
    #1 chk_all_zero("abort");
    bus.d_mem_w = 1'b0;
    next_cycle();
    reset            = 1'b0;
    bus.mem_ack      = 1'b1;
    bus.mem_readdata = 32'h12345678;
    @(negedge clk);
    chk("late_ack_busywait", 32'(bus.busywait), 32'h0);
    chk("late_ack_mem_req",  {30'b0, bus.mem_read, bus.mem_write}, 32'h0);
    next_cycle();
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_read_data", bus.read_data, 32'h0);
    next_cycle();
    run_txn(1'b1, 1'b0, F3_W, 32'h300, 32'h0, 2, 32'h0BADF00D, 1'b1, 4'b1111, 32'h0, 32'h0BADF00D);
    rd_model = 32'h0BADF00D;

    // Random traffic against a byte-addressed model.
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom());
    for (int n = 0; n < 200; n++) begin
      kind  = $urandom_range(0, 9);
      r     = (kind < 5) || (kind == 9);
      w     = (kind >= 5);
      f3    = r && !w ? 3'($urandom_range(0, 7)) : store_f3[$urandom_range(0, 8)];
      addr  = $urandom();
      wd    = $urandom();
      delay = $urandom_range(1, 4);
      case (f3)
        3'd0:    begin size = 1; sgn = 1'b1; end
        3'd1:    begin size = 2; sgn = 1'b1; end
        3'd2:    begin size = 4; sgn = 1'b0; end
        3'd4:    begin size = 1; sgn = 1'b0; end
        3'd5:    begin size = 2; sgn = 1'b0; end
        default: begin size = 0; sgn = 1'b0; end
      endcase
      off  = int'(addr[1:0]);
      base = int'({addr[7:2], 2'b00});
      ok   = (r != w) && (size != 0) && !(w && f3[2]) && ((off % (size == 0 ? 1 : size)) == 0);
      be    = 4'b0000;
      wdata = 32'h0;
      word  = {mem[base+3], mem[base+2], mem[base+1], mem[base]};
      if (ok) begin
        for (int i = 0; i < size; i++) be[off+i] = 1'b1;
        for (int j = 0; j < 4; j++) wdata[8*j +: 8] = wd[8*(j % size) +: 8];
        if (r) begin
          v = 0;
          for (int i = 0; i < size; i++) v += longint'(mem[base+off+i]) << (8*i);
          if (sgn && (size < 4) && (v >= (64'sd1 << (8*size-1)))) v -= (64'sd1 << (8*size));
          rd_model = v[31:0];
        end
      end
      run_txn(r, w, f3, addr, wd, delay, word, ok, be, wdata, rd_model);
      if (ok && w)
        for (int j = 0; j < 4; j++)
          if (be[j]) mem[base+j] = wdata[8*j +: 8];
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
